// File: rtl/sliding_window_pad_stream.sv
// Streaming KERNEL_HEIGHT x KERNEL_WIDTH window generator with built-in zero padding.
// Input elements arrive in raster order (row, column, channel; channel fastest). Padded
// positions are pushed internally without waiting for input, so each frame flushes on its own.
module sliding_window_pad_stream #(
    parameter int DATA_WIDTH    = 16,
    parameter int IMG_WIDTH     = 4,
    parameter int IMG_HEIGHT    = 4,
    parameter int CHANNELS      = 2,
    parameter int KERNEL_WIDTH  = 3,
    parameter int KERNEL_HEIGHT = 3,
    parameter int STRIDE_X      = 1,
    parameter int STRIDE_Y      = 1,
    parameter int PAD_W         = 1,
    parameter int PAD_H         = 1,
    parameter int PAD_VALUE     = 0,
    localparam int PW   = IMG_WIDTH + 2 * PAD_W,
    localparam int PH   = IMG_HEIGHT + 2 * PAD_H,
    localparam int OW   = (PW - KERNEL_WIDTH) / STRIDE_X + 1,
    localparam int OH   = (PH - KERNEL_HEIGHT) / STRIDE_Y + 1,
    localparam int OX_W = $clog2(OW) + 1,
    localparam int OY_W = $clog2(OH) + 1,
    localparam int PC_W = $clog2(CHANNELS) + 1
) (
    input  logic                                                clk,
    input  logic                                                rst,
    input  logic [DATA_WIDTH-1:0]                               data_in,
    input  logic                                                data_in_valid,
    output logic                                                data_in_ready,
    output logic [DATA_WIDTH*KERNEL_HEIGHT*KERNEL_WIDTH-1:0]    data_out,
    output logic [OX_W-1:0]                                     out_x,
    output logic [OY_W-1:0]                                     out_y,
    output logic [PC_W-1:0]                                     out_c,
    output logic                                                data_out_last,
    output logic                                                data_out_valid,
    input  logic                                                data_out_ready
);

    localparam int BUF   = PW * CHANNELS * (KERNEL_HEIGHT - 1) + (KERNEL_WIDTH - 1) * CHANNELS + 1;
    localparam int NWIN  = KERNEL_HEIGHT * KERNEL_WIDTH;
    localparam int PY_W  = $clog2(PH) + 1;
    localparam int PX_W  = $clog2(PW) + 1;
    localparam int PHX_W = $clog2(STRIDE_X) + 1;
    localparam int PHY_W = $clog2(STRIDE_Y) + 1;

    if (KERNEL_WIDTH <= PAD_W || KERNEL_HEIGHT <= PAD_H || STRIDE_X < 1 || STRIDE_Y < 1 ||
        KERNEL_WIDTH > PW || KERNEL_HEIGHT > PH || CHANNELS < 1 ||
        IMG_WIDTH < 1 || IMG_HEIGHT < 1 || DATA_WIDTH < 1) begin : g_bad_params
        $error("sliding_window_pad_stream: illegal parameter combination");
    end

    // Source position in the padded grid and stride phases
    logic [PY_W-1:0]  py_q, py_d;
    logic [PX_W-1:0]  px_q, px_d;
    logic [PC_W-1:0]  pc_q, pc_d;
    logic [PHX_W-1:0] phx_q, phx_d;
    logic [PHY_W-1:0] phy_q, phy_d;
    // Output-grid counters for the next emitted window
    logic [OX_W-1:0]  ox_q, ox_d;
    logic [OY_W-1:0]  oy_q, oy_d;

    logic [DATA_WIDTH-1:0] sr_q  [BUF];
    logic [DATA_WIDTH-1:0] sr_nx [BUF];
    logic [DATA_WIDTH-1:0] win_q [NWIN];
    logic [DATA_WIDTH-1:0] win_d [NWIN];

    logic [OX_W-1:0] out_x_q;
    logic [OY_W-1:0] out_y_q;
    logic [PC_W-1:0] out_c_q;
    logic            last_q;
    logic            valid_q;

    logic row_lo_ok, col_lo_ok, interior;
    logic stall, push, pix_end, row_end, emit, last_d;
    logic [DATA_WIDTH-1:0] new_elem;

    // A zero pad makes the lower bound trivially true; keep that out of the compare.
    if (PAD_H == 0) begin : g_row_lo_all
        assign row_lo_ok = 1'b1;
    end else begin : g_row_lo
        assign row_lo_ok = (py_q >= PY_W'(PAD_H));
    end
    if (PAD_W == 0) begin : g_col_lo_all
        assign col_lo_ok = 1'b1;
    end else begin : g_col_lo
        assign col_lo_ok = (px_q >= PX_W'(PAD_W));
    end

    assign interior = row_lo_ok && (py_q < PY_W'(PAD_H + IMG_HEIGHT)) &&
                      col_lo_ok && (px_q < PX_W'(PAD_W + IMG_WIDTH));
    assign stall    = valid_q && !data_out_ready;
    assign push     = !stall && (interior ? data_in_valid : 1'b1);
    assign data_in_ready = !stall && interior;
    assign new_elem = interior ? data_in : DATA_WIDTH'(PAD_VALUE);
    assign pix_end  = (pc_q == PC_W'(CHANNELS - 1));
    assign row_end  = pix_end && (px_q == PX_W'(PW - 1));
    assign emit     = push && (py_q >= PY_W'(KERNEL_HEIGHT - 1)) && (px_q >= PX_W'(KERNEL_WIDTH - 1)) &&
                      (phx_q == '0) && (phy_q == '0);
    assign last_d   = (ox_q == OX_W'(OW - 1)) && (oy_q == OY_W'(OH - 1)) && pix_end;

    // Next-state for source position, stride phases and output-grid counters
    always_comb begin
        pc_d  = pc_q;
        px_d  = px_q;
        py_d  = py_q;
        phx_d = phx_q;
        phy_d = phy_q;
        ox_d  = ox_q;
        oy_d  = oy_q;
        if (push) begin
            if (pix_end) begin
                pc_d = '0;
                px_d = (px_q == PX_W'(PW - 1)) ? '0 : px_q + PX_W'(1);
                // Phase restarts where the first full window column lands.
                if (px_d == PX_W'(KERNEL_WIDTH - 1) || phx_q == PHX_W'(STRIDE_X - 1)) begin
                    phx_d = '0;
                end else begin
                    phx_d = phx_q + PHX_W'(1);
                end
                if (row_end) begin
                    py_d = (py_q == PY_W'(PH - 1)) ? '0 : py_q + PY_W'(1);
                    if (py_d == PY_W'(KERNEL_HEIGHT - 1) || phy_q == PHY_W'(STRIDE_Y - 1)) begin
                        phy_d = '0;
                    end else begin
                        phy_d = phy_q + PHY_W'(1);
                    end
                end
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
        if (emit && pix_end) begin
            if (ox_q == OX_W'(OW - 1)) begin
                ox_d = '0;
                oy_d = (oy_q == OY_W'(OH - 1)) ? '0 : oy_q + OY_W'(1);
            end else begin
                ox_d = ox_q + OX_W'(1);
            end
        end
    end

    // Shifted buffer view (index 0 = element being pushed) and window tap selection
    always_comb begin
        sr_nx[0] = new_elem;
        for (int k = 1; k < BUF; k++) begin
            sr_nx[k] = sr_q[k-1];
        end
        for (int j = 0; j < KERNEL_HEIGHT; j++) begin
            for (int i = 0; i < KERNEL_WIDTH; i++) begin
                win_d[j*KERNEL_WIDTH + i] =
                    sr_nx[(KERNEL_HEIGHT - 1 - j) * PW * CHANNELS + (KERNEL_WIDTH - 1 - i) * CHANNELS];
            end
        end
    end

    // Position counters, stride phases and output-grid counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            py_q  <= '0;
            px_q  <= '0;
            pc_q  <= '0;
            phx_q <= '0;
            phy_q <= '0;
            ox_q  <= '0;
            oy_q  <= '0;
        end else begin
            py_q  <= py_d;
            px_q  <= px_d;
            pc_q  <= pc_d;
            phx_q <= phx_d;
            phy_q <= phy_d;
            ox_q  <= ox_d;
            oy_q  <= oy_d;
        end
    end

    // Line/element shift register, advanced on every push
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < BUF; k++) begin
                sr_q[k] <= '0;
            end
        end else if (push) begin
            for (int k = 0; k < BUF; k++) begin
                sr_q[k] <= sr_nx[k];
            end
        end
    end

    // Output register: load on emit, hold while stalled, drop valid on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NWIN; k++) begin
                win_q[k] <= '0;
            end
            out_x_q <= '0;
            out_y_q <= '0;
            out_c_q <= '0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
        end else if (emit) begin
            for (int k = 0; k < NWIN; k++) begin
                win_q[k] <= win_d[k];
            end
            out_x_q <= ox_q;
            out_y_q <= oy_q;
            out_c_q <= pc_q;
            last_q  <= last_d;
            valid_q <= 1'b1;
        end else if (data_out_ready) begin
            valid_q <= 1'b0;
        end
    end

    for (genvar k = 0; k < NWIN; k++) begin : g_pack
        assign data_out[k*DATA_WIDTH +: DATA_WIDTH] = win_q[k];
    end

    assign out_x          = out_x_q;
    assign out_y          = out_y_q;
    assign out_c          = out_c_q;
    assign data_out_last  = last_q;
    assign data_out_valid = valid_q;

endmodule

// File: tb/tb_sliding_window_pad_stream.sv
// Bench for sliding_window_pad_stream: four configurations on one clock, selected one at a time.
module tb_sliding_window_pad_stream;

    typedef struct {
        int iw, ih, ch, kw, kh, sx, sy, padw, padh;
    } cfg_t;

    typedef struct {
        logic [143:0] d;
        int           x, y, c;
        logic         last;
    } win_t;

    typedef struct {
        int   tid;
        int   idx;
        int   d[9];
        int   x, y, c;
        logic last;
    } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    int          sel;
    logic        vin;
    logic [15:0] din;
    logic        ordy;

    logic         ir0, ir1, ir2, ir3;
    logic [143:0] d0, d1, d2;
    logic [95:0]  d3;
    logic [2:0]   x0, y0, x2, y2;
    logic [1:0]   x1, y1, x3, y3, c2, c3;
    logic [0:0]   c0, c1;
    logic         l0, l1, l2, l3, v0, v1, v2, v3;

    sliding_window_pad_stream #(.CHANNELS(1)) u_t1 (
        .clk(clk), .rst(rst), .data_in(din), .data_in_valid(vin && sel == 0), .data_in_ready(ir0),
        .data_out(d0), .out_x(x0), .out_y(y0), .out_c(c0), .data_out_last(l0),
        .data_out_valid(v0), .data_out_ready(sel == 0 ? ordy : 1'b1));

    sliding_window_pad_stream #(.CHANNELS(1), .STRIDE_X(2), .STRIDE_Y(2)) u_t2 (
        .clk(clk), .rst(rst), .data_in(din), .data_in_valid(vin && sel == 1), .data_in_ready(ir1),
        .data_out(d1), .out_x(x1), .out_y(y1), .out_c(c1), .data_out_last(l1),
        .data_out_valid(v1), .data_out_ready(sel == 1 ? ordy : 1'b1));

    sliding_window_pad_stream #(.CHANNELS(2)) u_t4 (
        .clk(clk), .rst(rst), .data_in(din), .data_in_valid(vin && sel == 2), .data_in_ready(ir2),
        .data_out(d2), .out_x(x2), .out_y(y2), .out_c(c2), .data_out_last(l2),
        .data_out_valid(v2), .data_out_ready(sel == 2 ? ordy : 1'b1));

    sliding_window_pad_stream #(.IMG_WIDTH(4), .IMG_HEIGHT(3), .CHANNELS(2), .KERNEL_WIDTH(3),
                                .KERNEL_HEIGHT(2), .PAD_W(0), .PAD_H(0)) u_t6 (
        .clk(clk), .rst(rst), .data_in(din), .data_in_valid(vin && sel == 3), .data_in_ready(ir3),
        .data_out(d3), .out_x(x3), .out_y(y3), .out_c(c3), .data_out_last(l3),
        .data_out_valid(v3), .data_out_ready(sel == 3 ? ordy : 1'b1));

    // Selected DUT's outputs
    win_t cur;
    logic o_v, o_irdy;
    always_comb begin
        cur.d = '0; cur.x = 0; cur.y = 0; cur.c = 0; cur.last = 1'b0;
        o_v = 1'b0; o_irdy = 1'b0;
        case (sel)
            0: begin cur.d = d0; cur.x = int'(x0); cur.y = int'(y0); cur.c = int'(c0);
                     cur.last = l0; o_v = v0; o_irdy = ir0; end
            1: begin cur.d = d1; cur.x = int'(x1); cur.y = int'(y1); cur.c = int'(c1);
                     cur.last = l1; o_v = v1; o_irdy = ir1; end
            2: begin cur.d = d2; cur.x = int'(x2); cur.y = int'(y2); cur.c = int'(c2);
                     cur.last = l2; o_v = v2; o_irdy = ir2; end
            default: begin cur.d = {48'b0, d3}; cur.x = int'(x3); cur.y = int'(y3); cur.c = int'(c3);
                     cur.last = l3; o_v = v3; o_irdy = ir3; end
        endcase
    end

    int   total = 0;
    int   bad = 0;
    win_t exp_q[$];
    win_t got_q[$];
    cfg_t cfgs[4];
    vec_t tbl[7];

    function automatic string wstr(win_t w);
        return $sformatf("d=%h x=%0d y=%0d c=%0d last=%0b", w.d, w.x, w.y, w.c, w.last);
    endfunction

    function automatic void chk_i(string name, int act, int req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, req);
        end
    endfunction

    function automatic void chk_w(string name, win_t a, win_t b);
        total++;
        if (!(a.d == b.d && a.x == b.x && a.y == b.y && a.c == b.c && a.last == b.last)) begin
            bad++;
            $display("FAIL %s: got %s want %s", name, wstr(a), wstr(b));
        end
    endfunction

    // Reference: enumerate output windows straight from the padded-image definition.
    function automatic void model(cfg_t g, int vals[$]);
        int pw, ph, ow, oh, r, col, v;
        win_t w;
        pw = g.iw + 2 * g.padw;
        ph = g.ih + 2 * g.padh;
        ow = (pw - g.kw) / g.sx + 1;
        oh = (ph - g.kh) / g.sy + 1;
        exp_q.delete();
        for (int oy = 0; oy < oh; oy++)
            for (int ox = 0; ox < ow; ox++)
                for (int c = 0; c < g.ch; c++) begin
                    w.d = '0;
                    for (int j = 0; j < g.kh; j++)
                        for (int i = 0; i < g.kw; i++) begin
                            r   = oy * g.sy + j - g.padh;
                            col = ox * g.sx + i - g.padw;
                            v = (r >= 0 && r < g.ih && col >= 0 && col < g.iw) ? vals[(r * g.iw + col) * g.ch + c] : 0;
                            w.d[(j * g.kw + i) * 16 +: 16] = v[15:0];
                        end
                    w.x = ox; w.y = oy; w.c = c;
                    w.last = (ox == ow - 1) && (oy == oh - 1) && (c == g.ch - 1);
                    exp_q.push_back(w);
                end
    endfunction

    // Feed one frame into DUT s, collect accepted windows, check stall behaviour, compare with model.
    // With rst_after >= 0 the feed stops once that many inputs are taken and nothing is compared.
    task automatic run(input int s, input int vals[$], input bit bp, input int rst_after, input string tag);
        int   idx, cyc, drain, n, tmp;
        bit   have_snap;
        win_t snap;
        n = vals.size();
        if (rst_after < 0) model(cfgs[s], vals);
        else exp_q.delete();
        got_q.delete();
        sel = s; idx = 0; cyc = 0; drain = 0; have_snap = 0;
        while (1) begin
            @(negedge clk);
            tmp  = (idx < n) ? vals[idx] : 0;
            din  = tmp[15:0];
            vin  = (idx < n) && (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
            ordy = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (have_snap) begin
                chk_i({tag, "_hold_valid"}, int'(o_v), 1);
                chk_w({tag, "_hold_data"}, cur, snap);
            end
            have_snap = 0;
            if (o_v && !ordy) begin
                snap = cur;
                have_snap = 1;
                chk_i({tag, "_rdy_in_stall"}, int'(o_irdy), 0);
            end
            if (o_v && ordy) got_q.push_back(cur);
            if (vin && o_irdy) idx++;
            if (rst_after >= 0 && idx == rst_after) break;
            if (idx == n && got_q.size() >= exp_q.size()) drain++;
            if (drain == 20) break;
            cyc++;
            if (cyc > 3000) begin
                bad++; total++;
                $display("FAIL %s_timeout: got %0d windows want %0d", tag, got_q.size(), exp_q.size());
                break;
            end
        end
        if (rst_after < 0) begin
            chk_i({tag, "_count"}, got_q.size(), exp_q.size());
            for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
                chk_w($sformatf("%s_win%0d", tag, k), got_q[k], exp_q[k]);
        end
    endtask

    // Hand-derived spot values against the windows of the run just finished.
    task automatic apply_tbl(input int tid);
        win_t w;
        for (int t = 0; t < 7; t++) begin
            if (tbl[t].tid != tid) continue;
            w.d = '0;
            for (int k = 0; k < 9; k++) w.d[k*16 +: 16] = tbl[t].d[k][15:0];
            w.x = tbl[t].x; w.y = tbl[t].y; w.c = tbl[t].c; w.last = tbl[t].last;
            if (tbl[t].idx < got_q.size()) chk_w($sformatf("tbl_t%0d_i%0d", tid, tbl[t].idx), got_q[tbl[t].idx], w);
            else begin
                total++; bad++;
                $display("FAIL tbl_t%0d_i%0d: got no window want %s", tid, tbl[t].idx, wstr(w));
            end
        end
    endtask

    function automatic void seq_vals(output int q[$], input int n, input int base);
        q.delete();
        for (int k = 0; k < n; k++) q.push_back(base + k + 1);
    endfunction

    function automatic void rnd_vals(output int q[$], input int n);
        q.delete();
        for (int k = 0; k < n; k++) q.push_back(int'($urandom_range(0, 65535)));
    endfunction

    initial begin
        int vals[$];
        int tmpq[$];

        cfgs[0] = '{4, 4, 1, 3, 3, 1, 1, 1, 1};
        cfgs[1] = '{4, 4, 1, 3, 3, 2, 2, 1, 1};
        cfgs[2] = '{4, 4, 2, 3, 3, 1, 1, 1, 1};
        cfgs[3] = '{4, 3, 2, 3, 2, 1, 1, 0, 0};

        tbl[0] = '{1, 0,  '{0, 0, 0, 0, 1, 2, 0, 5, 6},             0, 0, 0, 1'b0};
        tbl[1] = '{1, 15, '{11, 12, 0, 15, 16, 0, 0, 0, 0},         3, 3, 0, 1'b1};
        tbl[2] = '{2, 1,  '{0, 0, 0, 2, 3, 4, 6, 7, 8},             1, 0, 0, 1'b0};
        tbl[3] = '{2, 3,  '{6, 7, 8, 10, 11, 12, 14, 15, 16},       1, 1, 0, 1'b1};
        tbl[4] = '{4, 1,  '{0, 0, 0, 0, 101, 102, 0, 105, 106},     0, 0, 1, 1'b0};
        tbl[5] = '{6, 0,  '{1, 3, 5, 9, 11, 13, 0, 0, 0},           0, 0, 0, 1'b0};
        tbl[6] = '{6, 7,  '{12, 14, 16, 20, 22, 24, 0, 0, 0},       1, 1, 1, 1'b1};

        rst = 1'b1; vin = 1'b0; din = '0; ordy = 1'b1; sel = 0;
        #12;
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            chk_i($sformatf("rst_valid_%0d", s), int'(o_v), 0);
            chk_i($sformatf("rst_last_%0d", s), int'(cur.last), 0);
            chk_i($sformatf("rst_xyc_%0d", s), cur.x + cur.y + cur.c, 0);
        end
        sel = 0;
        @(negedge clk);
        rst = 1'b0;

        // Top pad row (6) and left pad of row 1 are pushed with input ready low.
        for (int k = 0; k < 7; k++) begin
            #1;
            chk_i($sformatf("pad_rdy_%0d", k), int'(o_irdy), 0);
            @(negedge clk);
        end
        #1;
        chk_i("first_interior_rdy", int'(o_irdy), 1);

        // T1
        seq_vals(vals, 16, 0);
        run(0, vals, 1'b0, -1, "t1");
        apply_tbl(1);
        // T3: backpressure, same data then random data
        run(0, vals, 1'b1, -1, "t3a");
        rnd_vals(tmpq, 16);
        run(0, tmpq, 1'b1, -1, "t3b");
        // T5: back-to-back frame, then mid-frame reset and a fresh frame
        run(0, vals, 1'b0, -1, "t5a");
        run(0, vals, 1'b0, 7, "t5abort");
        @(posedge clk);
        #2 rst = 1'b1;
        vin = 1'b0;
        #1;
        chk_i("async_rst_valid", int'(o_v), 0);
        chk_i("async_rst_xy", cur.x + cur.y, 0);
        @(negedge clk);
        rst = 1'b0;
        run(0, vals, 1'b0, -1, "t5b");
        apply_tbl(1);

        // T2: stride 2
        run(1, vals, 1'b0, -1, "t2");
        apply_tbl(2);
        rnd_vals(tmpq, 16);
        run(1, tmpq, 1'b1, -1, "t2r");

        // T4: two channels, ch0 = n, ch1 = 100+n
        vals.delete();
        for (int k = 1; k <= 16; k++) begin
            vals.push_back(k);
            vals.push_back(100 + k);
        end
        run(2, vals, 1'b0, -1, "t4");
        apply_tbl(4);
        rnd_vals(tmpq, 32);
        run(2, tmpq, 1'b1, -1, "t4r");

        // T6: no padding, 4x3x2, kernel 3x2
        seq_vals(vals, 24, 0);
        run(3, vals, 1'b0, -1, "t6");
        apply_tbl(6);
        rnd_vals(tmpq, 24);
        run(3, tmpq, 1'b1, -1, "t6r");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
